// File: rtl/make_serout.sv
// make_serout: parallel-to-serial frame generator, LSB first,
// with optional even-parity bit and forced inter-frame idle gap.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-low
//   io_in_valid  parallel word offered
//   io_in_ready  word accepted this cycle when valid is also high
//   io_in_bits   parallel word, WIDTH bits
//   io_sout      serial data, LSB first
//   io_sframe    high while io_sout carries a data or parity bit
//   io_sstart    high only on the data bit 0 cycle
//   io_busy      high whenever the FSM is not idle
module make_serout #(
    parameter int WIDTH  = 16,
    parameter int PARITY = 0,
    parameter int GAP    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_sout,
    output logic             io_sframe,
    output logic             io_sstart,
    output logic             io_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR,
        GAPW
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    // Unreachable when GAP is 0; GAPW is never entered then.
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             par_bit;
    logic             par_nxt;
    logic [3:0]       gcnt;
    logic [3:0]       gcnt_nxt;
    logic             last_bit;
    logic             gap_last;
    logic             accept;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            gcnt    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
            gcnt    <= gcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        gcnt_nxt  = gcnt;

        // Final frame-bit cycle: last data bit, or the parity bit.
        last_bit = ((state == SHIFT) && (cnt == CNT_LAST) && (PARITY == 0))
                 || (state == PAR);
        gap_last = (GAP != 0) && (state == GAPW) && (gcnt == GAP_LAST);

        // Ready decodes registered state only, so no input reaches
        // an output combinationally.
        io_in_ready = (state == IDLE)
                    || ((GAP == 0) && last_bit)
                    || gap_last;
        accept = io_in_valid && io_in_ready;

        io_sframe = (state == SHIFT) || (state == PAR);
        io_sstart = (state == SHIFT) && (cnt == '0);
        io_busy   = (state != IDLE);
        io_sout   = 1'b0;
        if (state == SHIFT) begin
            io_sout = shreg[0];
        end else if (state == PAR) begin
            io_sout = par_bit;
        end

        unique case (state)
            IDLE: begin
            end
            SHIFT: begin
                shreg_nxt = shreg >> 1;
                if (cnt == CNT_LAST) begin
                    if (PARITY != 0) begin
                        state_nxt = PAR;
                    end else if (GAP != 0) begin
                        state_nxt = GAPW;
                        gcnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PAR: begin
                if (GAP != 0) begin
                    state_nxt = GAPW;
                    gcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAPW: begin
                if (gcnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Acceptance overrides the exit path of the final cycle,
        // giving back-to-back frames without a bubble.
        if (accept) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            shreg_nxt = io_in_bits;
            par_nxt   = ^io_in_bits;
        end
    end

endmodule

// File: tb/tb_make_serout.sv
// tb_make_serout: directed checks of make_serout in its default,
// parity and gap configurations.
module tb_make_serout;

    logic clock = 1'b0;
    logic reset;

    logic        v0, r0, so0, sf0, ss0, bz0;
    logic [15:0] b0;
    logic        v1, r1, so1, sf1, ss1, bz1;
    logic [15:0] b1;
    logic        v2, r2, so2, sf2, ss2, bz2;
    logic [15:0] b2;

    int npass = 0;
    int ntotal = 0;
    logic [15:0] w;

    always #5 clock = ~clock;

    make_serout u0 (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (v0),
        .io_in_ready (r0),
        .io_in_bits  (b0),
        .io_sout     (so0),
        .io_sframe   (sf0),
        .io_sstart   (ss0),
        .io_busy     (bz0)
    );

    make_serout #(.WIDTH(16), .PARITY(1), .GAP(0)) u1 (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (v1),
        .io_in_ready (r1),
        .io_in_bits  (b1),
        .io_sout     (so1),
        .io_sframe   (sf1),
        .io_sstart   (ss1),
        .io_busy     (bz1)
    );

    make_serout #(.WIDTH(16), .PARITY(0), .GAP(3)) u2 (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (v2),
        .io_in_ready (r2),
        .io_in_bits  (b2),
        .io_sout     (so2),
        .io_sframe   (sf2),
        .io_sstart   (ss2),
        .io_busy     (bz2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        b0 = '0; b1 = '0; b2 = '0;
        tick();
        tick();

        // reset state
        chk("rst_ready", r0, 1);
        chk("rst_busy", bz0, 0);
        chk("rst_sout", so0, 0);
        chk("rst_sframe", sf0, 0);
        chk("rst_sstart", ss0, 0);
        chk("rst_busy_par", bz1, 0);
        chk("rst_busy_gap", bz2, 0);
        reset = 1'b1;
        tick();

        // single frame A5C3
        b0 = 16'hA5C3;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("a5c3_sout%0d", i), so0, w[i]);
            chk($sformatf("a5c3_sframe%0d", i), sf0, 1);
            chk($sformatf("a5c3_sstart%0d", i), ss0, i == 0);
            chk($sformatf("a5c3_ready%0d", i), r0, i == 15);
            chk($sformatf("a5c3_busy%0d", i), bz0, 1);
            tick();
        end
        chk("a5c3_end_sframe", sf0, 0);
        chk("a5c3_end_busy", bz0, 0);
        chk("a5c3_end_ready", r0, 1);

        // back-to-back 0001 then 8000
        b0 = 16'h0001;
        v0 = 1'b1;
        tick();
        b0 = 16'h8000;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b1_sout%0d", i), so0, i == 0);
            chk($sformatf("b2b1_ready%0d", i), r0, i == 15);
            tick();
        end
        v0 = 1'b0;
        chk("b2b2_sstart", ss0, 1);
        chk("b2b2_sframe", sf0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b2_sout%0d", i), so0, i == 15);
            tick();
        end
        chk("b2b2_end_busy", bz0, 0);

        // input activity mid-frame must not disturb the word
        b0 = 16'h3C96;
        v0 = 1'b1;
        tick();
        w = 16'h3C96;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tog_sout%0d", i), so0, w[i]);
            v0 = (i == 15) ? 1'b0 : i[0];
            b0 = 16'($urandom);
            tick();
        end
        v0 = 1'b0;
        chk("tog_end_busy", bz0, 0);

        // reset mid-frame in cycle 8, with valid during reset
        b0 = 16'hFFFF;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (7) tick();
        chk("mrst_pre_sout", so0, 1);
        chk("mrst_pre_busy", bz0, 1);
        reset = 1'b0;
        v0 = 1'b1;
        b0 = 16'h1234;
        tick();
        chk("mrst_busy", bz0, 0);
        chk("mrst_sframe", sf0, 0);
        chk("mrst_ready", r0, 1);
        chk("mrst_sstart", ss0, 0);
        chk("mrst_sout", so0, 0);
        reset = 1'b1;
        v0 = 1'b0;
        tick();
        chk("mrst_no_accept", bz0, 0);
        b0 = 16'h0002;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        chk("mrst_new_sstart", ss0, 1);
        chk("mrst_new_bit0", so0, 0);
        tick();
        chk("mrst_new_bit1", so0, 1);
        chk("mrst_new_sstart1", ss0, 0);
        repeat (15) tick();
        chk("mrst_new_end_busy", bz0, 0);

        // parity: 0007 -> 1
        b1 = 16'h0007;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("par7_sframe%0d", i), sf1, 1);
            chk($sformatf("par7_ready%0d", i), r1, 0);
            chk($sformatf("par7_sout%0d", i), so1, i < 3);
            tick();
        end
        chk("par7_pbit", so1, 1);
        chk("par7_sframe", sf1, 1);
        chk("par7_sstart", ss1, 0);
        chk("par7_ready", r1, 1);
        chk("par7_busy", bz1, 1);
        tick();
        chk("par7_end_busy", bz1, 0);
        chk("par7_end_sframe", sf1, 0);

        // parity: 0003 -> 0
        b1 = 16'h0003;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (16) tick();
        chk("par3_pbit", so1, 0);
        chk("par3_sframe", sf1, 1);
        tick();
        chk("par3_end_busy", bz1, 0);

        // GAP=3 back-to-back
        b2 = 16'h00FF;
        v2 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("gap_sframe%0d", i), sf2, 1);
            chk($sformatf("gap_ready%0d", i), r2, 0);
            chk($sformatf("gap_sout%0d", i), so2, i < 8);
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("gapw_sframe%0d", g), sf2, 0);
            chk($sformatf("gapw_sout%0d", g), so2, 0);
            chk($sformatf("gapw_busy%0d", g), bz2, 1);
            chk($sformatf("gapw_ready%0d", g), r2, g == 2);
            tick();
        end
        v2 = 1'b0;
        chk("gap2_sstart", ss2, 1);
        chk("gap2_sframe", sf2, 1);
        repeat (16) tick();
        chk("gap2_tail_sframe", sf2, 0);
        chk("gap2_tail_busy", bz2, 1);
        chk("gap2_tail_ready", r2, 0);
        repeat (3) tick();
        chk("gap2_end_busy", bz2, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
